// File: rtl/adc_framer_pkg.sv
// Shared types and constants for the ADC burst framer: word tags, header layout
// and the output FSM state encoding.
package adc_framer_pkg;

    localparam logic [1:0] TAG_PAD  = 2'b00;
    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_LAST = 2'b11;

    localparam int HDR_TAG_W = 2;
    localparam int HDR_RSV_W = 14;
    localparam int HDR_SEQ_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAD  = 2'd3
    } framer_state_t;

    function automatic logic [HDR_TAG_W+HDR_RSV_W+HDR_SEQ_W-1:0] make_header(
        input logic [HDR_SEQ_W-1:0] seq
    );
        return {TAG_HDR, {HDR_RSV_W{1'b0}}, seq};
    endfunction

endpackage

// File: rtl/adc_burst_framer_if.sv
// AXI-Stream style bundle used for both the capture input and the framed output.
// A beat transfers on a rising edge where tvalid and tready are both high; while
// tvalid is high and tready low the master holds tdata/tlast and keeps tvalid up.
interface adc_burst_framer_if #(
    parameter int DW = 32
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/framer_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is accepted
// when a read frees the slot on the same edge.
module framer_fifo #(
    parameter int DW = 33,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_rd;
    logic          do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_burst_framer.sv
// Buffers the non-backpressured ADC sample stream and re-emits each series padded
// to whole BURST_LEN bursts. Define ADC_FRAMER_HEADER_EN to prefix a sequence header.
module adc_burst_framer
    import adc_framer_pkg::*;
#(
    parameter int BURST_LEN = 32,
    parameter int FIFO_AW   = 10
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    adc_burst_framer_if.slave    s_axis,
    adc_burst_framer_if.master   m_axis,
    input  logic                 clear_stats,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [31:0]          overflow_count,
    output logic [31:0]          packets_sent,
    output framer_state_t        fsm_state
);
    localparam int              BW       = $clog2(BURST_LEN);
    localparam logic [BW-1:0]   BEAT_MAX = BW'(BURST_LEN - 1);

    framer_state_t state;
    framer_state_t state_n;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_n;
    logic [15:0]   seq;
    logic          close_pending;
    logic          close_clr;

    logic [32:0]   fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    logic          out_valid;
    logic          out_last;
    logic [31:0]   out_data;
    logic          can_load;
    logic          load;
    logic          load_last;
    logic [31:0]   load_data;
    logic          tlast_hs;

    // The capture stage cannot be stalled, so ready is tied high.
    assign s_axis.tready = 1'b1;

    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tdata  = out_data;
    assign fsm_state     = state;

    assign drop     = s_axis.tvalid && fifo_full && !pop;
    assign can_load = !out_valid || m_axis.tready;
    assign tlast_hs = out_valid && out_last && m_axis.tready;

    framer_fifo #(
        .DW (33),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (s_axis.tvalid),
        .wr_data ({s_axis.tlast, s_axis.tdata}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

`ifdef ADC_FRAMER_HEADER_EN
    logic [15:0] hdr_seq;
    // A held tlast beat may complete on the very edge the header loads.
    assign hdr_seq = tlast_hs ? (seq + 16'd1) : seq;
`endif

    always_comb begin
        state_n   = state;
        beat_n    = beat_cnt;
        pop       = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = '0;
        close_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                beat_n = '0;
                if (!fifo_empty) begin
`ifdef ADC_FRAMER_HEADER_EN
                    state_n = ST_HDR;
`else
                    state_n = ST_DATA;
`endif
                end
            end
`ifdef ADC_FRAMER_HEADER_EN
            ST_HDR: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = make_header(hdr_seq);
                    beat_n    = beat_cnt + 1'b1;
                    state_n   = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                if (!fifo_empty) begin
                    if (can_load) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_data = fifo_rd_data[31:0];
                        if (fifo_rd_data[32] && beat_cnt == BEAT_MAX) begin
                            load_last = 1'b1;
                            beat_n    = '0;
                            state_n   = ST_IDLE;
                        end else begin
                            beat_n = beat_cnt + 1'b1;
                            if (fifo_rd_data[32]) begin
                                state_n = ST_PAD;
                            end
                        end
                    end
                end else if (close_pending) begin
                    // The series' last word was dropped: close it with padding.
                    close_clr = 1'b1;
                    state_n   = (beat_cnt == '0) ? ST_IDLE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = {TAG_PAD, 30'd0};
                    if (beat_cnt == BEAT_MAX) begin
                        load_last = 1'b1;
                        beat_n    = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            seq           <= '0;
            close_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            if (close_clr) begin
                close_pending <= 1'b0;
            end
            if (drop && s_axis.tlast) begin
                close_pending <= 1'b1;
            end
            if (tlast_hs) begin
                seq <= seq + 16'd1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_last  <= load_last;
                out_data  <= load_data;
            end else if (out_valid && m_axis.tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_count <= '0;
            packets_sent   <= '0;
        end else if (clear_stats) begin
            overflow_count <= '0;
            packets_sent   <= '0;
        end else begin
            if (drop && overflow_count != 32'hFFFF_FFFF) begin
                overflow_count <= overflow_count + 32'd1;
            end
            if (tlast_hs) begin
                packets_sent <= packets_sent + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_burst_framer.sv
// Randomized bench for adc_burst_framer against a packet-level model: each series
// becomes [header] + words + zero pads rounded up to whole bursts.
module tb_adc_burst_framer;
    import adc_framer_pkg::*;

    localparam int BL    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ADC_FRAMER_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          clear_stats;
    logic [AW:0]   fifo_level;
    logic [31:0]   overflow_count;
    logic [31:0]   packets_sent;
    framer_state_t fsm_state;

    adc_burst_framer_if #(.DW(32)) s_if ();
    adc_burst_framer_if #(.DW(32)) m_if ();

    adc_burst_framer #(
        .BURST_LEN (BL),
        .FIFO_AW   (AW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .clear_stats    (clear_stats),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .packets_sent   (packets_sent),
        .fsm_state      (fsm_state)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    int          model_seq;
    int          model_pkts;
    int          pkt_beats;
    bit          in_pkt;
    int          rdy_pct = 100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        exp_q.delete();
        model_seq  = 0;
        model_pkts = 0;
        pkt_beats  = 0;
        in_pkt     = 1'b0;
    endfunction

    function automatic void model_finish();
        int pads;
        pads = (BL - (pkt_beats % BL)) % BL;
        for (int i = 0; i < pads; i++) begin
            exp_q.push_back({(i == pads - 1), 32'h0000_0000});
        end
        model_seq  = (model_seq + 1) % 65536;
        model_pkts = model_pkts + 1;
        in_pkt     = 1'b0;
    endfunction

    function automatic void model_word(input bit last, input logic [31:0] data);
        logic [15:0] s16;
        if (!in_pkt) begin
            in_pkt    = 1'b1;
            pkt_beats = 0;
            if (HDR_EN) begin
                s16 = 16'(model_seq);
                exp_q.push_back({1'b0, 2'b01, 14'd0, s16});
                pkt_beats = 1;
            end
        end
        pkt_beats++;
        if (!last) begin
            exp_q.push_back({1'b0, data});
        end else begin
            exp_q.push_back({((pkt_beats % BL) == 0), data});
            model_finish();
        end
    endfunction

    // Series whose last word was dropped: closed at the stored words.
    function automatic void model_close();
        if (in_pkt) begin
            if ((pkt_beats % BL) == 0) begin
                in_pkt = 1'b0;
            end else begin
                model_finish();
            end
        end
    endfunction

    function automatic logic [31:0] rand_word(input bit last);
        logic [14:0] a;
        logic [14:0] b;
        a = 15'($urandom);
        b = 15'($urandom);
        return {(last ? TAG_LAST : TAG_DATA), a, b};
    endfunction

    // ---------------- drivers ----------------
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            m_if.tready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic send_word(input bit last, input logic [31:0] data, input bit clr);
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        s_if.tdata  = data;
        clear_stats = clr;
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send_packet(input int n, input bit throttle, input int gap_pct);
        bit          last;
        logic [31:0] data;
        int          t;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            data = rand_word(last);
            if (throttle) begin
                t = 0;
                while (exp_q.size() >= 12 && t < 2000) begin
                    tick();
                    t++;
                end
                check("throttle_wait", 64'(t < 2000), 64'd1);
            end
            model_word(last, data);
            send_word(last, data, 1'b0);
            if ($urandom_range(99) < gap_pct) begin
                tick();
            end
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    // ---------------- output monitor / scoreboard ----------------
    logic        hold_pending = 1'b0;
    logic [32:0] held;

    always @(negedge aclk) begin
        if (!aresetn) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(m_if.tvalid), 64'd1);
                check("hold_beat", 64'({m_if.tlast, m_if.tdata}), 64'(held));
            end
            hold_pending = m_if.tvalid && !m_if.tready;
            held         = {m_if.tlast, m_if.tdata};
            if (m_if.tvalid && m_if.tready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("beat", 64'({m_if.tlast, m_if.tdata}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int          stored;
        bit          last;
        logic [31:0] w;

        aresetn     = 1'b0;
        clear_stats = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        check("rst_pkts", 64'(packets_sent), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        aresetn = 1'b1;
        tick();

        // short series and exact / one-over burst sizes
        rdy_pct = 100;
        send_packet(3, 1'b0, 0);
        drain("drain_short");
        check("pkts_short", 64'(packets_sent), 64'(model_pkts));
        send_packet(BL, 1'b0, 0);
        send_packet(BL + 1, 1'b0, 0);
        drain("drain_burst");
        check("pkts_burst", 64'(packets_sent), 64'(model_pkts));

        // latency with the framer waiting in DATA on an empty FIFO
        w = rand_word(1'b0);
        model_word(1'b0, w);
        send_word(1'b0, w, 1'b0);
        drain("drain_lat0");
        w = rand_word(1'b1);
        model_word(1'b1, w);
        send_word(1'b1, w, 1'b0);
        @(negedge aclk);
        check("lat_n1", 64'(m_if.tvalid), 64'd0);
        @(negedge aclk);
        check("lat_n2", 64'(m_if.tvalid), 64'd1);
        @(posedge aclk);
        #1;
        drain("drain_lat1");

        // randomized series under varying backpressure
        for (int p = 0; p < 14; p++) begin
            case ($urandom_range(2))
                0:       rdy_pct = 30;
                1:       rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            send_packet($urandom_range(1, 3 * BL), 1'b1, 25);
        end
        rdy_pct = 100;
        drain("drain_rand");
        check("pkts_rand", 64'(packets_sent), 64'(model_pkts));
        check("ovf_rand", 64'(overflow_count), 64'd0);

        // overflow with output stalled: FIFO plus the output slot fill, rest drop
        rdy_pct = 0;
        tick();
        tick();
        stored = DEPTH + (HDR_EN ? 0 : 1);
        for (int i = 0; i < DEPTH + 8; i++) begin
            last = (i == DEPTH + 7);
            w    = rand_word(last);
            if (i < stored) begin
                model_word(1'b0, w);
            end
            send_word(last, w, 1'b0);
        end
        tick();
        tick();
        check("ovf_count", 64'(overflow_count), 64'(DEPTH + 8 - stored));
        check("ovf_level", 64'(fifo_level), 64'(DEPTH));
        check("ovf_valid", 64'(m_if.tvalid), 64'd1);
        send_word(1'b0, rand_word(1'b0), 1'b1);
        model_pkts = 0;
        check("clr_wins", 64'(overflow_count), 64'd0);
        check("clr_pkts", 64'(packets_sent), 64'd0);
        send_word(1'b0, rand_word(1'b0), 1'b0);
        check("drop_after_clr", 64'(overflow_count), 64'd1);
        model_close();
        rdy_pct = 100;
        drain("drain_ovf");
        check("pkts_ovf", 64'(packets_sent), 64'(model_pkts));

        // reset in the middle of a buffered series
        rdy_pct = 0;
        tick();
        tick();
        send_packet(10, 1'b0, 0);
        tick();
        tick();
        aresetn = 1'b0;
        model_reset();
        tick();
        check("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_state", 64'(fsm_state), 64'(ST_IDLE));
        aresetn = 1'b1;
        tick();
        check("mid_rst_ovf", 64'(overflow_count), 64'd0);
        check("mid_rst_pkts", 64'(packets_sent), 64'd0);
        rdy_pct = 100;
        send_packet(5, 1'b0, 0);
        drain("drain_post_rst");
        check("pkts_post_rst", 64'(packets_sent), 64'(model_pkts));
        check("level_end", 64'(fifo_level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
